fft_mem_ctrl: RTL and testbench
===============================

Name: fft_mem_ctrl

Overview:
- Frame-level sequencer for the FFT ping-pong memory pair and its mux.
- Drives axis_rx, axis_tx, wmem_id and rmem_id to the memory mux.
- Hands off to the stream-to-memory writer, the butterfly stage engine and the memory-to-stream reader with start/done handshakes.
- One frame per run: RX into mem0, NUM_STAGES in-place ping-pong passes, TX out of mem0.

Parameters:
FFT_SIZE, 4096, points per frame; informational, checked by NUM_STAGES == log2(FFT_SIZE)
NUM_STAGES, 12, butterfly passes per frame; must be even so the result lands in mem0
STAGE_W, 4, width of stage_idx; must satisfy 2**STAGE_W >= NUM_STAGES
GAP_CYCLES, 2, idle cycles after each stage_done (RAM read/write pipeline drain); 0 is legal
FCNT_W, 16, width of frame_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  frame request; level sampled in IDLE only
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at frame completion
rx_start  out  1  one-cycle pulse to stream-to-memory writer
rx_done  in  1  writer finished FFT_SIZE samples
stage_start  out  1  one-cycle pulse to stage engine
stage_done  in  1  stage engine finished the current pass
stage_idx  out  STAGE_W  current pass number, 0..NUM_STAGES-1
tx_start  out  1  one-cycle pulse to memory-to-stream reader
tx_done  in  1  reader finished the frame
axis_rx  out  1  mux select: stream writes into mem0
axis_tx  out  1  mux select: stream reads from mem0
wmem_id  out  1  FFT write bank
rmem_id  out  1  FFT read bank
frame_count  out  FCNT_W  completed frames, wraps modulo 2**FCNT_W

Behaviour:
- All outputs are registered. Clock is clk; reset is asynchronous, active-high on rst.
- Reset values:
  - state = IDLE.
  - All pulses, busy, axis_rx and axis_tx = 0.
  - wmem_id = 1, rmem_id = 0, stage_idx = 0, frame_count = 0.
- Idle bank setting (wmem_id=1, rmem_id=0) keeps mem0 free for RX/TX. The mux gives axis_rx/axis_tx priority on mem0.
- States: IDLE, RX, STG_START, STG_RUN, GAP, TX, FIN.
- IDLE:
  - start=1 → RX next cycle.
  - In the first RX cycle, axis_rx=1, rx_start=1 and busy=1 are all visible.
- RX:
  - axis_rx held at 1.
  - rx_done is ignored in the cycle rx_start is high.
  - Otherwise rx_done=1 → STG_START, with axis_rx=0 in the same next cycle.
- STG_START: lasts one cycle.
  - stage_start=1.
  - rmem_id = stage_idx[0] and wmem_id = ~stage_idx[0], both already valid in this cycle.
  - Next state: STG_RUN.
- STG_RUN: wait for stage_done=1.
  - GAP_CYCLES > 0 → GAP.
  - GAP_CYCLES = 0 → take the GAP exit directly.
- GAP:
  - Down-counter loaded with GAP_CYCLES-1; the state lasts exactly GAP_CYCLES cycles.
  - Exit when stage_idx == NUM_STAGES-1: → TX, and stage_idx resets to 0.
  - Otherwise: stage_idx += 1, bank ids toggle, → STG_START.
- TX:
  - Bank ids return to the idle setting (wmem_id=1, rmem_id=0).
  - axis_tx=1; tx_start pulses in the first TX cycle; tx_done is ignored in that cycle.
  - tx_done → FIN.
- FIN: lasts one cycle.
  - done=1 and frame_count increments.
  - Next state is IDLE; busy=0 from the next cycle.
  - start is not accepted in FIN; earliest restart is start high in the first IDLE cycle.
- Handshake rules:
  - start while busy: ignored, never queued.
  - Stray rx_done/stage_done/tx_done outside their waiting state: ignored.
  - stage_done asserted in the STG_START cycle is ignored; the engine has at least one cycle of latency.
- Mutual exclusion: axis_rx and axis_tx are never high together. Both are low throughout all STG_*/GAP states.
- Reset mid-operation: all state, counters and outputs return to reset values immediately. frame_count is cleared. No done pulse is generated.
- Minimum frame latency from start to done:
  - 1 (IDLE→RX) + RX duration
  - + NUM_STAGES × (1 + run + GAP_CYCLES)
  - + TX duration + 1 (FIN).

Decomposition:
- fft_defs.vh gains:
  - FFT_NUM_STAGES and FFT_STAGE_W defines.
  - Localparam-style state encodings FMC_IDLE..FMC_FIN, 3-bit binary.
- A single module; no sub-module. The GAP down-counter is inline (≤ 8 bits, sized from GAP_CYCLES).

Test Plan:
1. Reset values: rst pulse, no start → busy=0, wmem_id=1, rmem_id=0, stage_idx=0, frame_count=0; all pulses stay 0 for 100 cycles.
2. Full frame (GAP_CYCLES=2, NUM_STAGES=12; models: rx_done after 4096 cycles, stage_done 10 cycles after each stage_start, tx_done after 4096 cycles):
   - exactly 12 stage_start pulses;
   - rmem_id/wmem_id = 0/1, 1/0, ... alternating;
   - stage_idx 0..11;
   - exactly one done pulse; frame_count=1; busy low in the cycle after done.
3. Spurious inputs:
   - start held high throughout a frame → exactly one frame runs;
   - tx_done pulsed during STG_RUN → ignored;
   - stage_done pulsed during RX → ignored;
   - axis_rx and axis_tx never both 1.
4. GAP_CYCLES=0 build: stage_done → next stage_start exactly 1 cycle later.
5. Mid-frame reset: rst asserted in STG_RUN at stage_idx=5 → outputs equal reset values immediately, no done pulse; a fresh start completes normally with frame_count=1.
6. Back-to-back: start high in the first IDLE cycle after done → RX entered next cycle. Run 3 frames → frame_count=3. Build with FCNT_W=2 and run 4 frames → frame_count wraps to 0.

Source files
------------

// File: rtl/fft_mem_ctrl_pkg.sv
// Shared definitions for the FFT ping-pong memory frame sequencer.
// The state encoding and default stage geometry live here for all users.
package fft_mem_ctrl_pkg;

   localparam int FFT_NUM_STAGES = 12;
   localparam int FFT_STAGE_W    = 4;

   typedef enum logic [2:0] {
      FMC_IDLE      = 3'd0,
      FMC_RX        = 3'd1,
      FMC_STG_START = 3'd2,
      FMC_STG_RUN   = 3'd3,
      FMC_GAP       = 3'd4,
      FMC_TX        = 3'd5,
      FMC_FIN       = 3'd6
   } fmc_state_e;

   // Bits needed to hold GAP_CYCLES-1; a 1-bit counter is kept even when unused.
   function automatic int gap_cnt_width(input int gap_cycles);
      return (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
   endfunction

endpackage

// File: rtl/fft_mem_ctrl.sv
// Frame-level sequencer: RX into mem0, NUM_STAGES in-place ping-pong
// butterfly passes, then TX out of mem0, with start/done handshakes.
module fft_mem_ctrl
   import fft_mem_ctrl_pkg::*;
#(
   parameter int FFT_SIZE   = 4096,
   parameter int NUM_STAGES = FFT_NUM_STAGES,
   parameter int STAGE_W    = FFT_STAGE_W,
   parameter int GAP_CYCLES = 2,
   parameter int FCNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rx_start,
   input  logic              rx_done,
   output logic              stage_start,
   input  logic              stage_done,
   output logic [STAGE_W-1:0] stage_idx,
   output logic              tx_start,
   input  logic              tx_done,
   output logic              axis_rx,
   output logic              axis_tx,
   output logic              wmem_id,
   output logic              rmem_id,
   output logic [FCNT_W-1:0] frame_count
);

   localparam int                 GAP_W      = gap_cnt_width(GAP_CYCLES);
   localparam logic [GAP_W-1:0]   GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

   if ((NUM_STAGES != $clog2(FFT_SIZE)) || (NUM_STAGES % 2 != 0) ||
       ((2 ** STAGE_W) < NUM_STAGES)) begin : g_cfg_check
      $error("fft_mem_ctrl: inconsistent FFT_SIZE / NUM_STAGES / STAGE_W");
   end

   fmc_state_e       state;
   logic [GAP_W-1:0] gap_cnt;
   logic             gap_exit;

   // A zero-length gap folds the GAP exit into the stage_done cycle of STG_RUN.
   assign gap_exit = ((state == FMC_GAP) && (gap_cnt == '0)) ||
                     ((state == FMC_STG_RUN) && stage_done && (GAP_CYCLES == 0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FMC_IDLE;
         gap_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         rx_start    <= 1'b0;
         stage_start <= 1'b0;
         tx_start    <= 1'b0;
         axis_rx     <= 1'b0;
         axis_tx     <= 1'b0;
         wmem_id     <= 1'b1;
         rmem_id     <= 1'b0;
         stage_idx   <= '0;
         frame_count <= '0;
      end else begin
         rx_start    <= 1'b0;
         stage_start <= 1'b0;
         tx_start    <= 1'b0;
         done        <= 1'b0;

         case (state)
            FMC_IDLE: begin
               if (start) begin
                  state    <= FMC_RX;
                  busy     <= 1'b1;
                  axis_rx  <= 1'b1;
                  rx_start <= 1'b1;
               end
            end
            FMC_RX: begin
               // rx_start still high means this is the first RX cycle.
               if (rx_done && !rx_start) begin
                  state       <= FMC_STG_START;
                  axis_rx     <= 1'b0;
                  stage_start <= 1'b1;
                  rmem_id     <= stage_idx[0];
                  wmem_id     <= ~stage_idx[0];
               end
            end
            FMC_STG_START: begin
               state <= FMC_STG_RUN;
            end
            FMC_STG_RUN: begin
               if (stage_done && (GAP_CYCLES > 0)) begin
                  state   <= FMC_GAP;
                  gap_cnt <= GAP_LOAD;
               end
            end
            FMC_GAP: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            FMC_TX: begin
               if (tx_done && !tx_start) begin
                  state       <= FMC_FIN;
                  axis_tx     <= 1'b0;
                  done        <= 1'b1;
                  frame_count <= frame_count + 1'b1;
               end
            end
            FMC_FIN: begin
               state <= FMC_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= FMC_IDLE;
            end
         endcase

         if (gap_exit) begin
            if (stage_idx == LAST_STAGE) begin
               state     <= FMC_TX;
               stage_idx <= '0;
               wmem_id   <= 1'b1;
               rmem_id   <= 1'b0;
               axis_tx   <= 1'b1;
               tx_start  <= 1'b1;
            end else begin
               state       <= FMC_STG_START;
               stage_idx   <= stage_idx + 1'b1;
               wmem_id     <= ~wmem_id;
               rmem_id     <= ~rmem_id;
               stage_start <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Randomized bench for fft_mem_ctrl: three builds (default, zero gap, 2-bit
// frame counter) checked cycle by cycle against a frame timeline model.
module tb_fft_mem_ctrl;

   localparam int NS = 12;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rx_start;
      logic       stage_start;
      logic       tx_start;
      logic       axis_rx;
      logic       axis_tx;
      logic       wmem;
      logic       rmem;
      logic [3:0] idx;
   } outs_t;

   logic        clk;
   logic        rst_a         [3];
   logic        start_a       [3];
   logic        rx_done_a     [3];
   logic        stage_done_a  [3];
   logic        tx_done_a     [3];
   logic        busy_a        [3];
   logic        done_a        [3];
   logic        rx_start_a    [3];
   logic        stage_start_a [3];
   logic        tx_start_a    [3];
   logic        axis_rx_a     [3];
   logic        axis_tx_a     [3];
   logic        wmem_a        [3];
   logic        rmem_a        [3];
   logic [3:0]  idx_a         [3];
   logic [15:0] fc_a          [3];

   int n_tests = 0;
   int n_fail  = 0;
   int exp_fc [3];

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int G  = (k == 1) ? 0 : 2;
      localparam int FW = (k == 2) ? 2 : 16;
      logic [FW-1:0] fc;
      fft_mem_ctrl #(
         .FFT_SIZE   (4096),
         .NUM_STAGES (NS),
         .STAGE_W    (4),
         .GAP_CYCLES (G),
         .FCNT_W     (FW)
      ) u_dut (
         .clk         (clk),
         .rst         (rst_a[k]),
         .start       (start_a[k]),
         .busy        (busy_a[k]),
         .done        (done_a[k]),
         .rx_start    (rx_start_a[k]),
         .rx_done     (rx_done_a[k]),
         .stage_start (stage_start_a[k]),
         .stage_done  (stage_done_a[k]),
         .stage_idx   (idx_a[k]),
         .tx_start    (tx_start_a[k]),
         .tx_done     (tx_done_a[k]),
         .axis_rx     (axis_rx_a[k]),
         .axis_tx     (axis_tx_a[k]),
         .wmem_id     (wmem_a[k]),
         .rmem_id     (rmem_a[k]),
         .frame_count (fc)
      );
      assign fc_a[k] = 16'(fc);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int gap_of(input int k);
      return (k == 1) ? 0 : 2;
   endfunction

   function automatic int fmask(input int k);
      return (k == 2) ? 3 : 32'hFFFF;
   endfunction

   function automatic outs_t idle_out();
      outs_t o;
      o      = '0;
      o.wmem = 1'b1;
      return o;
   endfunction

   // Expected outputs at cycle c of a frame (c = 0 is the first RX cycle).
   function automatic outs_t model(input int c, input int lrx, input int ls,
                                   input int ltx, input int g);
      outs_t o;
      int p, t, f, stg, off;
      o = idle_out();
      p = 1 + ls + g;
      t = lrx + 1 + NS * p;
      f = t + ltx + 1;
      if (c < 0 || c > f) return o;
      o.busy = 1'b1;
      if (c <= lrx) begin
         o.axis_rx  = 1'b1;
         o.rx_start = (c == 0);
      end else if (c < t) begin
         stg           = (c - lrx - 1) / p;
         off           = (c - lrx - 1) % p;
         o.stage_start = (off == 0);
         o.idx         = 4'(stg);
         o.rmem        = (stg % 2 == 1);
         o.wmem        = (stg % 2 == 0);
      end else if (c < f) begin
         o.axis_tx  = 1'b1;
         o.tx_start = (c == t);
      end else begin
         o.done = 1'b1;
      end
      return o;
   endfunction

   function automatic outs_t observe(input int k);
      outs_t o;
      o.busy        = busy_a[k];
      o.done        = done_a[k];
      o.rx_start    = rx_start_a[k];
      o.stage_start = stage_start_a[k];
      o.tx_start    = tx_start_a[k];
      o.axis_rx     = axis_rx_a[k];
      o.axis_tx     = axis_tx_a[k];
      o.wmem        = wmem_a[k];
      o.rmem        = rmem_a[k];
      o.idx         = idx_a[k];
      return o;
   endfunction

   task automatic clear_in(input int k);
      rx_done_a[k]    = 1'b0;
      stage_done_a[k] = 1'b0;
      tx_done_a[k]    = 1'b0;
   endtask

   task automatic idle_cycles(input int k, input int n, input bit stray);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("idle", 32'(observe(k)), 32'(idle_out()));
         check("idle_fcnt", 32'(fc_a[k]), 32'(exp_fc[k] & fmask(k)));
         rx_done_a[k]    = stray && ($urandom_range(0, 3) == 0);
         stage_done_a[k] = stray && ($urandom_range(0, 3) == 0);
         tx_done_a[k]    = stray && ($urandom_range(0, 3) == 0);
      end
      clear_in(k);
   endtask

   task automatic pulse_reset(input int k);
      @(posedge clk); #1;
      rst_a[k]   = 1'b1;
      start_a[k] = 1'b0;
      clear_in(k);
      exp_fc[k]  = 0;
      #1;
      check("rst_outs", 32'(observe(k)), 32'(idle_out()));
      check("rst_fcnt", 32'(fc_a[k]), 32'd0);
      @(posedge clk); #1;
      rst_a[k] = 1'b0;
   endtask

   // One frame with reactive engine models; optional stray pulses, held start,
   // back-to-back restart and a reset at the start of stage abort_at's run.
   task automatic run_frame(input int k, input int lrx, input int ls, input int ltx,
                            input bit hold, input bit inj, input bit chain,
                            input int abort_at);
      int g, p, t, f, rc, sc, tc, n_ss, n_done, c_abort, off;
      outs_t o;
      g       = gap_of(k);
      p       = 1 + ls + g;
      t       = lrx + 1 + NS * p;
      f       = t + ltx + 1;
      c_abort = (abort_at >= 0) ? lrx + 1 + abort_at * p + 1 : -1;
      rc = 0; sc = 0; tc = 0; n_ss = 0; n_done = 0;
      start_a[k] = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c <= f + 1; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (c == f) exp_fc[k]++;
         o = observe(k);
         check("outs", 32'(o), 32'(model(c, lrx, ls, ltx, g)));
         check("excl", 32'(o.axis_rx & o.axis_tx), 32'd0);
         check("fcnt", 32'(fc_a[k]), 32'(exp_fc[k] & fmask(k)));
         n_ss   += int'(o.stage_start);
         n_done += int'(o.done);
         if (c == c_abort) begin
            rst_a[k]   = 1'b1;
            start_a[k] = 1'b0;
            clear_in(k);
            exp_fc[k]  = 0;
            #1;
            check("abort_outs", 32'(observe(k)), 32'(idle_out()));
            check("abort_fcnt", 32'(fc_a[k]), 32'd0);
            @(posedge clk); #1;
            check("abort_hold", 32'(observe(k)), 32'(idle_out()));
            rst_a[k] = 1'b0;
            idle_cycles(k, 20, 1'b1);
            return;
         end
         clear_in(k);
         if (o.rx_start) rc = lrx;
         else if (rc > 0) begin
            rc--;
            if (rc == 0) rx_done_a[k] = 1'b1;
         end
         if (o.stage_start) sc = ls;
         else if (sc > 0) begin
            sc--;
            if (sc == 0) stage_done_a[k] = 1'b1;
         end
         if (o.tx_start) tc = ltx;
         else if (tc > 0) begin
            tc--;
            if (tc == 0) tx_done_a[k] = 1'b1;
         end
         if (inj) begin
            if (c == 0) rx_done_a[k] = 1'b1;
            if (c == 1) begin
               stage_done_a[k] = 1'b1;
               tx_done_a[k]    = 1'b1;
            end
            if (c > lrx && c < t) begin
               off = (c - lrx - 1) % p;
               if (off == 0) stage_done_a[k] = 1'b1;
               if (off == 1) begin
                  tx_done_a[k] = 1'b1;
                  rx_done_a[k] = 1'b1;
               end
               if (g > 0 && off == ls + 1) stage_done_a[k] = 1'b1;
            end
            if (c == t) tx_done_a[k] = 1'b1;
            if (c == t + 1) begin
               stage_done_a[k] = 1'b1;
               rx_done_a[k]    = 1'b1;
            end
            if (c == f) tx_done_a[k] = 1'b1;
         end
         start_a[k] = (c <= f) ? hold : chain;
      end
      clear_in(k);
      check("n_stage_start", 32'(n_ss), 32'(NS));
      check("n_done", 32'(n_done), 32'd1);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_a[k]   = 1'b1;
         start_a[k] = 1'b0;
         clear_in(k);
         exp_fc[k]  = 0;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         check("reset_outs", 32'(observe(k)), 32'(idle_out()));
         check("reset_fcnt", 32'(fc_a[k]), 32'd0);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst_a[k] = 1'b0;

      idle_cycles(0, 100, 1'b0);
      idle_cycles(1, 10, 1'b1);
      idle_cycles(2, 10, 1'b1);

      // Full-size frame with nominal engine latencies.
      run_frame(0, 4096, 10, 4096, 1'b0, 1'b0, 1'b0, -1);
      check("fc_full", 32'(fc_a[0]), 32'd1);
      idle_cycles(0, 5, 1'b1);

      // Start held high and stray handshakes.
      for (int i = 0; i < 3; i++) begin
         run_frame(0, $urandom_range(1, 30), $urandom_range(1, 12), $urandom_range(1, 30),
                   1'b1, 1'b1, 1'b0, -1);
         idle_cycles(0, 10, 1'b1);
      end

      // Reset during stage 5, then a fresh frame.
      run_frame(0, $urandom_range(1, 30), $urandom_range(1, 12), $urandom_range(1, 30),
                1'b0, 1'b1, 1'b0, 5);
      run_frame(0, $urandom_range(1, 30), $urandom_range(1, 12), $urandom_range(1, 30),
                1'b0, 1'b0, 1'b0, -1);
      check("fc_after_rst", 32'(fc_a[0]), 32'd1);
      idle_cycles(0, 5, 1'b1);

      // Back-to-back frames.
      pulse_reset(0);
      for (int i = 0; i < 3; i++) begin
         run_frame(0, $urandom_range(1, 30), $urandom_range(1, 12), $urandom_range(1, 30),
                   1'(i % 2), 1'b1, (i < 2), -1);
      end
      check("fc_b2b", 32'(fc_a[0]), 32'd3);
      idle_cycles(0, 5, 1'b1);

      // Zero-gap build.
      for (int i = 0; i < 4; i++) begin
         run_frame(1, $urandom_range(1, 30), $urandom_range(1, 12), $urandom_range(1, 30),
                   1'(i % 2), 1'b1, 1'b0, -1);
         idle_cycles(1, 3, 1'b1);
      end

      // 2-bit frame counter wraps after four frames.
      for (int i = 0; i < 4; i++) begin
         run_frame(2, $urandom_range(1, 30), $urandom_range(1, 12), $urandom_range(1, 30),
                   1'b0, 1'b1, (i < 3), -1);
      end
      check("fc_wrap", 32'(fc_a[2]), 32'd0);
      idle_cycles(2, 5, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
